// File: rtl/iram_fetch_unit.sv
// iram_fetch_unit: PC-driven fetch from a registered-read instruction ROM with a valid/ready hand-off to decode.
// Define IRAM_FETCH_COUNT_EN to add the saturating fetch_count acceptance counter.
module iram_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [3:0] END_OPCODE = 4'b1111
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_address,
  input  logic [DATA_W-1:0] iram_q,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
`ifdef IRAM_FETCH_COUNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              busy,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              accept, is_end, start_ok;
  assign accept       = ir_valid_q & ir_ready;
  assign is_end       = ir_q[DATA_W-1 -: 4] == END_OPCODE;
  assign start_ok     = start & (state_q == IDLE || state_q == HALT);
  assign iram_address = pc_q;
  assign ir           = ir_q;
  assign ir_pc        = ir_pc_q;
  assign ir_valid     = ir_valid_q;
  assign busy         = state_q == ISSUE || state_q == CAPTURE || state_q == PRESENT;
  assign halted       = state_q == HALT;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE, HALT: begin
        pc_d    = start ? START_ADDR : pc_q;
        state_d = start ? ISSUE : state_q;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        ir_d       = iram_q;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(1);
        state_d    = PRESENT;
      end
      PRESENT: if (accept) begin
        // An END word wins over any simultaneous redirect
        ir_valid_d = 1'b0;
        state_d    = is_end ? HALT : ISSUE;
        pc_d       = (!is_end && branch_valid) ? branch_target : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= START_ADDR;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end
`ifdef IRAM_FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d       = start_ok ? '0 : (accept && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign fetch_count = cnt_q;
  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif
endmodule

// File: tb/tb_iram_fetch_unit.sv
// tb_iram_fetch_unit: scoreboard bench for iram_fetch_unit with a registered-read ROM model.
module tb_iram_fetch_unit;
  logic        clock = 0, reset_n = 0, start = 0, ir_ready = 0, branch_valid = 0;
  logic [7:0]  iram_address, ir_pc, branch_target = 0;
  logic [15:0] iram_q = 0, ir;
  logic        ir_valid, busy, halted;
`ifdef IRAM_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif
  logic [15:0] rom [256];
  logic [23:0] exp_q [$];
  int checks = 0, errors = 0;

  iram_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .iram_address(iram_address),
    .iram_q(iram_q), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
`ifdef IRAM_FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;
  always @(posedge clock) iram_q <= rom[iram_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [7:0] a);
    exp_q.push_back({w, a});
  endtask

  // Wait (bounded) for a presented word, then accept it with the given redirect inputs
  task automatic accept_one(input logic bv, input logic [7:0] tgt);
    for (int i = 0; i < 8 && !ir_valid; i++) tick();
    chk("valid_wait", ir_valid, 1);
    ir_ready = 1; branch_valid = bv; branch_target = tgt;
    tick();
    ir_ready = 0; branch_valid = 0;
  endtask

  always @(negedge clock) begin
    logic [23:0] e;
    if (reset_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_ir", ir, e[23:8]);
        chk("sb_ir_pc", ir_pc, e[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1200; rom[1] = 16'h3506; rom[2] = 16'hAA00; rom[3] = 16'hF000;
    tick(); tick();
    reset_n = 1;
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", iram_address, 0);
    // Linear fetch with ir_ready tied high: timing and spacing
    push(16'h1200, 0); push(16'h3506, 1); push(16'hAA00, 2); push(16'hF000, 3);
    ir_ready = 1; start = 1;
    tick(); start = 0;
    chk("issue_busy", busy, 1);
    chk("issue_valid", ir_valid, 0);
    tick();
    chk("capture_valid", ir_valid, 0);
    tick();
    chk("first_valid", ir_valid, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); chk("gap1_valid", ir_valid, 0);
      tick(); chk("gap2_valid", ir_valid, 0);
      tick(); chk("space_valid", ir_valid, 1);
    end
    tick(); ir_ready = 0;
    chk("lin_halted", halted, 1);
    chk("lin_busy", busy, 0);
    chk("lin_ir_hold", ir, 16'hF000);
`ifdef IRAM_FETCH_COUNT_EN
    chk("lin_count", fetch_count, 4);
`endif
    // Backpressure, plus start and branch ignored while not accepting
    push(16'h1200, 0); push(16'h3506, 1); push(16'hAA00, 2); push(16'hF000, 3);
    start = 1; tick(); start = 0;
    chk("restart_halted", halted, 0);
    accept_one(0, 0);
    tick(); tick();
    chk("bp_present", ir_valid, 1);
    start = 1; branch_valid = 1; branch_target = 8'h40;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ir", ir, 16'h3506);
      chk("bp_ir_pc", ir_pc, 1);
      chk("bp_valid", ir_valid, 1);
      chk("bp_addr", iram_address, 2);
    end
    start = 0; branch_valid = 0;
    accept_one(0, 0);
    chk("bp_no_redirect", iram_address, 2);
    accept_one(0, 0); accept_one(0, 0);
    chk("bp_halted", halted, 1);
`ifdef IRAM_FETCH_COUNT_EN
    chk("bp_count", fetch_count, 4);
`endif
    // Branches: 0 -> 0x20 -> 0x06, then linear to END
    rom[0] = 16'h1000; rom[8'h20] = 16'h2020; rom[6] = 16'h6006; rom[7] = 16'hF000;
    push(16'h1000, 0); push(16'h2020, 8'h20); push(16'h6006, 6); push(16'hF000, 7);
    start = 1; tick(); start = 0;
    accept_one(1, 8'h20); accept_one(1, 8'h06); accept_one(0, 0); accept_one(0, 0);
    chk("br_halted", halted, 1);
    // END beats a simultaneous redirect
    rom[5] = 16'hF000;
    push(16'h1000, 0); push(16'hF000, 5);
    start = 1; tick(); start = 0;
    accept_one(1, 8'h05); accept_one(1, 8'h30);
    chk("end_halted", halted, 1);
    chk("end_pc", iram_address, 6);
    // Restart, then wrap 0xFF -> 0x00
    rom[8'hFF] = 16'h5FFF;
    push(16'h1000, 0); push(16'h5FFF, 8'hFF); push(16'h1000, 0);
    start = 1; tick(); start = 0;
    chk("end_restart_halted", halted, 0);
    chk("end_restart_addr", iram_address, 0);
    accept_one(1, 8'hFF); accept_one(0, 0); accept_one(0, 0);
    chk("wrap_addr", iram_address, 1);
    // Reset in CAPTURE
    tick();
    chk("pre_rst_busy", busy, 1);
    reset_n = 0; tick(); reset_n = 1;
    chk("mid_rst_valid", ir_valid, 0);
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_ir_pc", ir_pc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", iram_address, 0);
    push(16'h1000, 0); push(16'hF000, 7);
    start = 1; tick(); start = 0;
    accept_one(1, 8'h07); accept_one(0, 0);
    chk("post_rst_halted", halted, 1);
`ifdef IRAM_FETCH_COUNT_EN
    chk("post_rst_count", fetch_count, 2);
`endif
    tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
